axis_frame_source: RTL and testbench

AXI-Stream video transmitter that emits raster frames of FRAME_WIDTH × FRAME_HEIGHT pixels, with programmable line and frame blanking. It marks start-of-frame on tuser and end-of-line on tlast. It is the upstream counterpart of the mean filter's slave port, and it drives the filter input in simulation and on-board bring-up. All pixel, flag and handshake behaviour follows the stream convention that the filter consumes.

---
 rtl/mean_filter_pkg.sv | 27 ++
 rtl/prbs16.sv | 29 ++
 rtl/axis_frame_source.sv | 185 ++++++++++++++++++
 tb/tb_axis_frame_source.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mean_filter_pkg.sv
// Shared types and constants for the mean filter stream path: pattern and
// source FSM encodings plus the PRBS16 polynomial used by source and checkers.
package mean_filter_pkg;

   typedef enum logic [1:0] {
      PAT_HRAMP   = 2'd0,
      PAT_VRAMP   = 2'd1,
      PAT_CHECKER = 2'd2,
      PAT_PRBS    = 2'd3
   } pattern_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_HBLANK = 2'd2,
      ST_VBLANK = 2'd3
   } state_e;

   localparam logic [15:0] PRBS_SEED = 16'hACE1;
   // Fibonacci taps for x^16+x^14+x^13+x^11+1 seen from the shift-right end.
   localparam logic [15:0] PRBS_TAPS = 16'h002D;

   function automatic logic [15:0] prbs16_step(input logic [15:0] s);
      return {^(s & PRBS_TAPS), s[15:1]};
   endfunction

endpackage

// File: rtl/prbs16.sv
// 16-bit Fibonacci LFSR with synchronous reseed and gated advance; reseed wins
// over advance so a frame start always begins from PRBS_SEED.
module prbs16
   import mean_filter_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_load,
   input  logic        i_advance,
   output logic [15:0] o_state
);

   logic [15:0] r_state;

   // NOTE: state registers use non-blocking assignments with the asynchronous
   // reset in the sensitivity list, so every flop clears the moment rst_n drops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= PRBS_SEED;
      end else if (i_load) begin
         r_state <= PRBS_SEED;
      end else if (i_advance) begin
         r_state <= prbs16_step(r_state);
      end
   end

   assign o_state = r_state;

endmodule

// File: rtl/axis_frame_source.sv
// AXI-Stream raster frame generator with line/frame blanking, tuser on the
// first pixel of a frame and tlast on the last pixel of each line.
module axis_frame_source
   import mean_filter_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int FRAME_WIDTH  = 640,
   parameter int FRAME_HEIGHT = 512,
   parameter int HBLANK       = 16,
   parameter int VBLANK       = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic [1:0]            pattern_sel,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   output logic                  m_axis_tlast,
   output logic                  m_axis_tuser,
   input  logic                  m_axis_tready,
   output logic                  busy,
   output logic                  frame_done
);

   localparam int XW        = $clog2(FRAME_WIDTH);
   localparam int YW        = $clog2(FRAME_HEIGHT);
   localparam int BLANK_MAX = (HBLANK > VBLANK) ? ((HBLANK > 1) ? HBLANK : 1)
                                                : ((VBLANK > 1) ? VBLANK : 1);
   localparam int BW        = (BLANK_MAX > 1) ? $clog2(BLANK_MAX) : 1;

   localparam logic [XW-1:0] X_LAST  = XW'(FRAME_WIDTH - 1);
   localparam logic [YW-1:0] Y_LAST  = YW'(FRAME_HEIGHT - 1);
   localparam logic [BW-1:0] HB_LAST = BW'((HBLANK > 0) ? HBLANK - 1 : 0);
   localparam logic [BW-1:0] VB_LAST = BW'((VBLANK > 0) ? VBLANK - 1 : 0);

   state_e                r_state,  w_state_nxt;
   pattern_e              r_pat,    w_pat_nxt;
   logic [XW-1:0]         r_x,      w_x_nxt;
   logic [YW-1:0]         r_y,      w_y_nxt;
   logic [BW-1:0]         r_blank,  w_blank_nxt;
   logic [DATA_WIDTH-1:0] r_tdata,  w_tdata_nxt;
   logic                  r_tvalid, w_tvalid_nxt;
   logic                  r_tlast,  w_tlast_nxt;
   logic                  r_tuser,  w_tuser_nxt;
   logic                  r_busy,   w_busy_nxt;
   logic                  r_done,   w_done_nxt;
   logic                  w_fire;
   logic                  w_decide;
   logic                  w_prbs_load;
   logic                  w_prbs_adv;
   logic [15:0]           w_prbs_state;
   logic [15:0]           w_prbs_nxt;

   function automatic logic [DATA_WIDTH-1:0] pixel(
      input pattern_e        pat,
      input logic [XW-1:0]   x,
      input logic [YW-1:0]   y,
      input logic [15:0]     prbs
   );
      logic chk;
      chk = 1'(32'(x) >> 3) ^ 1'(32'(y) >> 3);
      case (pat)
         PAT_HRAMP:   return DATA_WIDTH'(x);
         PAT_VRAMP:   return DATA_WIDTH'(y);
         PAT_CHECKER: return {DATA_WIDTH{chk}};
         default:     return DATA_WIDTH'(prbs);
      endcase
   endfunction

   assign w_fire = r_tvalid & m_axis_tready;

   prbs16 u_prbs (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_load    (w_prbs_load),
      .i_advance (w_prbs_adv),
      .o_state   (w_prbs_state)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_pat    <= PAT_HRAMP;
         r_x      <= '0;
         r_y      <= '0;
         r_blank  <= '0;
         r_tdata  <= '0;
         r_tvalid <= 1'b0;
         r_tlast  <= 1'b0;
         r_tuser  <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_pat    <= w_pat_nxt;
         r_x      <= w_x_nxt;
         r_y      <= w_y_nxt;
         r_blank  <= w_blank_nxt;
         r_tdata  <= w_tdata_nxt;
         r_tvalid <= w_tvalid_nxt;
         r_tlast  <= w_tlast_nxt;
         r_tuser  <= w_tuser_nxt;
         r_busy   <= w_busy_nxt;
         r_done   <= w_done_nxt;
      end
   end

   // NOTE: every signal driven here gets a default first, so no path through
   // the case statement can leave a value unassigned and infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_pat_nxt   = r_pat;
      w_x_nxt     = r_x;
      w_y_nxt     = r_y;
      w_blank_nxt = r_blank;
      w_decide    = 1'b0;
      w_prbs_load = 1'b0;
      w_prbs_adv  = 1'b0;
      w_done_nxt  = 1'b0;
      case (r_state)
         ST_IDLE: w_decide = 1'b1;
         ST_ACTIVE: begin
            if (w_fire) begin
               w_prbs_adv = 1'b1;
               if (r_x == X_LAST) begin
                  w_x_nxt     = '0;
                  w_blank_nxt = '0;
                  if (r_y == Y_LAST) begin
                     w_y_nxt    = '0;
                     w_done_nxt = 1'b1;
                     if (VBLANK == 0) w_decide = 1'b1;
                     else             w_state_nxt = ST_VBLANK;
                  end else begin
                     w_y_nxt = r_y + YW'(1);
                     if (HBLANK != 0) w_state_nxt = ST_HBLANK;
                  end
               end else begin
                  w_x_nxt = r_x + XW'(1);
               end
            end
         end
         ST_HBLANK: begin
            if (r_blank == HB_LAST) w_state_nxt = ST_ACTIVE;
            else                    w_blank_nxt = r_blank + BW'(1);
         end
         ST_VBLANK: begin
            if (r_blank == VB_LAST) w_decide    = 1'b1;
            else                    w_blank_nxt = r_blank + BW'(1);
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      // Frame-start decision: the only place pattern_sel is sampled.
      if (w_decide) begin
         w_x_nxt = '0;
         w_y_nxt = '0;
         if (enable) begin
            w_state_nxt = ST_ACTIVE;
            w_pat_nxt   = pattern_e'(pattern_sel);
            w_prbs_load = 1'b1;
         end else begin
            w_state_nxt = ST_IDLE;
         end
      end
   end

   // Outputs are computed from next-state values so the registered beat is
   // already correct on the edge that enters or stays in ACTIVE.
   always_comb begin
      w_prbs_nxt   = w_prbs_load ? PRBS_SEED
                   : (w_prbs_adv ? prbs16_step(w_prbs_state) : w_prbs_state);
      w_tvalid_nxt = (w_state_nxt == ST_ACTIVE);
      w_tdata_nxt  = w_tvalid_nxt ? pixel(w_pat_nxt, w_x_nxt, w_y_nxt, w_prbs_nxt) : '0;
      w_tlast_nxt  = w_tvalid_nxt && (w_x_nxt == X_LAST);
      w_tuser_nxt  = w_tvalid_nxt && (w_x_nxt == '0) && (w_y_nxt == '0);
      w_busy_nxt   = (w_state_nxt != ST_IDLE);
   end

   assign m_axis_tdata  = r_tdata;
   assign m_axis_tvalid = r_tvalid;
   assign m_axis_tlast  = r_tlast;
   assign m_axis_tuser  = r_tuser;
   assign busy          = r_busy;
   assign frame_done    = r_done;

endmodule

// File: tb/tb_axis_frame_source.sv
// Self-checking bench: scoreboard of expected beats for a 4x3 source, plus a
// 16x16 zero-blanking instance for checkerboard, back-to-back and PRBS checks.
module tb_axis_frame_source;

   localparam int AW = 4;
   localparam int AH = 3;
   localparam int BN = 16;

   logic       clk = 1'b0;
   logic       rst_n, enable, tready;
   logic [1:0] pattern_sel;
   logic [7:0] tdata;
   logic       tvalid, tlast, tuser, busy, frame_done;

   logic       b_rst_n, b_enable;
   logic [1:0] b_pattern_sel;
   logic [7:0] b_tdata;
   logic       b_tvalid, b_tlast, b_tuser, b_busy, b_frame_done;
   logic       b_tready = 1'b1;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int fire_count = 0;
   bit rand_rdy = 1'b0;
   bit prev_stall = 1'b0;
   logic [9:0] prev_beat;
   int en_cyc;

   logic [9:0] sb[$];
   int         fire_cyc[$];
   int         done_cyc[$];
   logic [7:0] obs_data[$];
   logic [9:0] b_obs[$];
   int         b_cyc[$];

   axis_frame_source #(
      .DATA_WIDTH(8), .FRAME_WIDTH(AW), .FRAME_HEIGHT(AH), .HBLANK(2), .VBLANK(5)
   ) dut_a (
      .clk(clk), .rst_n(rst_n), .enable(enable), .pattern_sel(pattern_sel),
      .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tlast(tlast),
      .m_axis_tuser(tuser), .m_axis_tready(tready), .busy(busy), .frame_done(frame_done)
   );

   axis_frame_source #(
      .DATA_WIDTH(8), .FRAME_WIDTH(BN), .FRAME_HEIGHT(BN), .HBLANK(0), .VBLANK(0)
   ) dut_b (
      .clk(clk), .rst_n(b_rst_n), .enable(b_enable), .pattern_sel(b_pattern_sel),
      .m_axis_tdata(b_tdata), .m_axis_tvalid(b_tvalid), .m_axis_tlast(b_tlast),
      .m_axis_tuser(b_tuser), .m_axis_tready(b_tready), .busy(b_busy),
      .frame_done(b_frame_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   always @(posedge clk) begin
      #1;
      tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      logic fb;
      fb = s[0] ^ s[2] ^ s[3] ^ s[5];
      return {fb, s[15:1]};
   endfunction

   function automatic logic [7:0] pix(input logic [1:0] pat, input int x, input int y,
                                      input logic [15:0] s);
      case (pat)
         2'd0:    return x[7:0];
         2'd1:    return y[7:0];
         2'd2:    return ((((x >> 3) ^ (y >> 3)) & 1) != 0) ? 8'hFF : 8'h00;
         default: return s[7:0];
      endcase
   endfunction

   task automatic push_frame(input logic [1:0] pat);
      logic [15:0] s = 16'hACE1;
      for (int y = 0; y < AH; y++) begin
         for (int x = 0; x < AW; x++) begin
            sb.push_back({pix(pat, x, y, s), 1'(x == AW - 1), 1'(x == 0 && y == 0)});
            s = lfsr_next(s);
         end
      end
   endtask

   // Scoreboard monitor for instance A: sampled on the falling edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("stall_valid", 32'(tvalid), 32'd1);
            check("stall_stable", 32'({tdata, tlast, tuser}), 32'(prev_beat));
         end
         if (tvalid && tready) begin
            fire_count++;
            fire_cyc.push_back(cyc);
            obs_data.push_back(tdata);
            check("sb_has_entry", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) check("beat", 32'({tdata, tlast, tuser}), 32'(sb.pop_front()));
         end
         prev_stall = tvalid && !tready;
         prev_beat  = {tdata, tlast, tuser};
         if (frame_done) done_cyc.push_back(cyc);
      end
   end

   always @(negedge clk) begin
      if (b_rst_n && b_tvalid && b_tready) begin
         b_obs.push_back({b_tdata, b_tlast, b_tuser});
         b_cyc.push_back(cyc);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_fires(input int tgt);
      int t = 0;
      while (fire_count < tgt && t < 3000) begin
         tick(1);
         t++;
      end
      if (fire_count < tgt) check("tmo_fires", 32'(fire_count), 32'(tgt));
   endtask

   task automatic wait_idle();
      int t = 0;
      while (busy && t < 500) begin
         tick(1);
         t++;
      end
      if (busy) check("tmo_idle", 32'(busy), 32'd0);
   endtask

   task automatic run_frames(input int n, input logic [1:0] pat, input int drop_after,
                             input logic [1:0] pat_after);
      int base = fire_count;
      for (int i = 0; i < n; i++) push_frame(pat);
      pattern_sel = pat;
      enable      = 1'b1;
      en_cyc      = cyc;
      wait_fires(base + drop_after);
      enable      = 1'b0;
      pattern_sel = pat_after;
      wait_idle();
      check("sb_drained", 32'(sb.size()), 32'd0);
      check("idle_tvalid", 32'(tvalid), 32'd0);
      check("fire_total", 32'(fire_count - base), 32'(n * AW * AH));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int base, dbase, rel_cyc, gaps;
      logic [15:0] s;

      rst_n = 1'b0; enable = 1'b0; pattern_sel = 2'd0;
      b_rst_n = 1'b0; b_enable = 1'b0; b_pattern_sel = 2'd0;
      tick(3);
      check("rst_tvalid", 32'(tvalid), 32'd0);
      check("rst_tlast", 32'(tlast), 32'd0);
      check("rst_tuser", 32'(tuser), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(frame_done), 32'd0);
      check("rst_tdata", 32'(tdata), 32'd0);
      rst_n = 1'b1; b_rst_n = 1'b1;
      tick(2);

      // h-ramp, tready high: beat order via scoreboard, timing via fire cycles.
      base  = fire_count;
      dbase = done_cyc.size();
      run_frames(2, 2'd0, AW * AH + 1, 2'd0);
      check("first_latency", 32'(fire_cyc[base]), 32'(en_cyc + 1));
      check("line_len", 32'(fire_cyc[base + 3] - fire_cyc[base]), 32'd3);
      check("hblank_gap", 32'(fire_cyc[base + 4] - fire_cyc[base + 3]), 32'd3);
      check("frame_span", 32'(fire_cyc[base + 11] - fire_cyc[base]), 32'd15);
      check("frame_period", 32'(fire_cyc[base + 12] - fire_cyc[base]), 32'd21);
      check("done_time", 32'(done_cyc[dbase]), 32'(fire_cyc[base + 11] + 1));
      check("done_count", 32'(done_cyc.size() - dbase), 32'd2);
      tick(3);

      // Random backpressure: stability is checked in the monitor.
      rand_rdy = 1'b1;
      run_frames(2, 2'd0, AW * AH + 1, 2'd0);
      rand_rdy = 1'b0;
      tick(3);

      // PRBS, two frames, each reseeded.
      base = fire_count;
      run_frames(2, 2'd3, AW * AH + 1, 2'd3);
      check("prbs_first", 32'(obs_data[base]), 32'hE1);
      tick(3);

      // Enable dropped after 5 beats with pattern_sel changed: frame completes as h-ramp.
      run_frames(1, 2'd0, 5, 2'd1);
      check("drop_busy", 32'(busy), 32'd0);
      tick(3);
      run_frames(1, 2'd1, 1, 2'd1);
      tick(3);

      // Reset mid-line, then restart from (0,0).
      base = fire_count;
      push_frame(2'd0);
      pattern_sel = 2'd0;
      enable      = 1'b1;
      wait_fires(base + 2);
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_tvalid", 32'(tvalid), 32'd0);
      check("mid_rst_tlast", 32'(tlast), 32'd0);
      check("mid_rst_tuser", 32'(tuser), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_tdata", 32'(tdata), 32'd0);
      sb.delete();
      tick(1);
      push_frame(2'd0);
      base    = fire_count;
      rel_cyc = cyc;
      rst_n   = 1'b1;
      wait_fires(base + 1);
      enable = 1'b0;
      wait_idle();
      check("rst_restart_lat", 32'(fire_cyc[base]), 32'(rel_cyc + 1));
      check("rst_sb_drained", 32'(sb.size()), 32'd0);
      check("rst_fire_total", 32'(fire_count - base), 32'(AW * AH));

      // Instance B: 16x16 checkerboard, no blanking, two frames back to back.
      b_pattern_sel = 2'd2;
      b_enable      = 1'b1;
      begin
         int t = 0;
         while (b_obs.size() < BN * BN + 1 && t < 3000) begin tick(1); t++; end
      end
      b_enable = 1'b0;
      begin
         int t = 0;
         while (b_busy && t < 1000) begin tick(1); t++; end
      end
      check("b_count", 32'(b_obs.size()), 32'(2 * BN * BN));
      check("b_pix_8_0", 32'(b_obs[8][9:2]), 32'hFF);
      check("b_pix_8_8", 32'(b_obs[8 * BN + 8][9:2]), 32'h00);
      check("b_pix_0_8", 32'(b_obs[8 * BN][9:2]), 32'hFF);
      check("b_tlast_15", 32'(b_obs[BN - 1][1]), 32'd1);
      check("b_tuser_f2", 32'(b_obs[BN * BN][0]), 32'd1);
      gaps = 0;
      for (int i = 1; i < b_cyc.size(); i++) if (b_cyc[i] - b_cyc[i - 1] != 1) gaps++;
      check("b_gaps", 32'(gaps), 32'd0);

      // Instance B PRBS: first line is 16 consecutive LFSR states from the seed.
      b_obs.delete();
      tick(2);
      b_pattern_sel = 2'd3;
      b_enable      = 1'b1;
      begin
         int t = 0;
         while (b_obs.size() < 1 && t < 100) begin tick(1); t++; end
      end
      b_enable = 1'b0;
      begin
         int t = 0;
         while (b_busy && t < 1000) begin tick(1); t++; end
      end
      check("b_prbs_count", 32'(b_obs.size()), 32'(BN * BN));
      s = 16'hACE1;
      for (int i = 0; i < 16; i++) begin
         check("b_prbs", 32'(b_obs[i][9:2]), 32'(s[7:0]));
         s = lfsr_next(s);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
